ps2_cmd_decoder: RTL and testbench
==================================

Name: ps2_cmd_decoder

Overview:
- Sits between the PS/2 keyboard receiver and the game state machine.
- Consumes raw scan codes and returns the `read` acknowledge to the receiver.
- Strips the E0 (extended) and F0 (break) prefixes.
- Maps make codes to player directions and start/escape requests.
- Applies direction changes only on the game-step `tick`, so the game FSM always sees a stable, legal direction per step.

Parameters:
- NO_REVERSE, 1, when 1 a key requesting the direction opposite the committed direction is ignored.
- P1_INIT_DIR, 2'b01, player 1 direction loaded at reset/init (RIGHT).
- P2_INIT_DIR, 2'b11, player 2 direction loaded at reset/init (LEFT).
- Direction encoding, fixed: UP=00, RIGHT=01, DOWN=10, LEFT=11. Opposite(d) = d ^ 2'b10.

Ports:
- clk  in  1  system clock (divided board clock).
- reset  in  1  synchronous, active-low reset.
- scan_ready  in  1  from keyboard receiver; asynchronous to clk; high while a code is available.
- scan_code  in  8  scan code; stable while scan_ready is high.
- read  out  1  one-cycle acknowledge pulse to the receiver.
- tick  in  1  one-cycle game-step strobe.
- init_dirs  in  1  one-cycle request to reload initial directions (game FSM in its init state).
- p1_dir  out  2  committed player 1 direction.
- p2_dir  out  2  committed player 2 direction.
- start_req  out  1  sticky start request (space).
- esc_pulse  out  1  one-cycle escape indication.
- last_code  out  8  last captured scan code, for the SSD.

Behaviour:
- **Reset (reset==0 at clk edge):**
  - FSM to IDLE; read=0, esc_pulse=0, start_req=0, last_code=0.
  - Both synchronizer stages cleared.
  - Pending and committed directions set to P1_INIT_DIR / P2_INIT_DIR.
  - Reset mid-sequence (e.g. after E0) discards the prefix.
- **Input capture:**
  - scan_ready passes through a 2-flop synchronizer plus an edge-detect flop.
  - On the synchronized rising edge, scan_code is captured into last_code, and read pulses high on the next cycle for exactly one cycle.
  - A level held high produces exactly one capture.
- **Latency:** capture occurs on the 3rd clk edge after scan_ready rises. Decoded effects (pending update, start_req, esc_pulse) appear 1 cycle after capture.
- **Prefix FSM, states IDLE, EXT, BRK, EXT_BRK:**
  - IDLE:
    - E0 -> EXT; F0 -> BRK.
    - Make code -> action, stay IDLE.
    - P1 make codes: 1D=UP, 1B=DOWN, 1C=LEFT, 23=RIGHT.
    - P2 make codes (non-extended keypad form also accepted): 75=UP, 72=DOWN, 6B=LEFT, 74=RIGHT.
    - 29 sets start_req; 76 pulses esc_pulse.
    - Other codes: no action.
  - EXT:
    - F0 -> EXT_BRK; E0 stays EXT.
    - 75/72/6B/74 -> P2 action, then IDLE.
    - Other codes -> IDLE, no action.
  - BRK, EXT_BRK: any code -> IDLE, no action (key releases are ignored).
- **Direction pipeline:**
  - A P1/P2 action writes that player's pending direction.
  - When NO_REVERSE=1, the write is dropped if the requested direction is Opposite of the reference direction.
  - On tick, committed <= pending for both players.
  - Reference direction: the committed value normally. If tick occurs in the same cycle as the action, the reference is the pending value being committed in that cycle.
  - Later key presses before a tick overwrite pending; last legal press wins.
- **init_dirs:** loads pending and committed with the init values. It overrides a same-cycle tick and a same-cycle key action.
- **start_req:** set by a space make; cleared on tick. If set and tick occur in the same cycle, set wins. init_dirs does not clear it.
- **Unknown FSM state:** recover to IDLE.

Decomposition:
- Shared package `lbike_pkg`: direction localparams UP/RIGHT/DOWN/LEFT, scan-code constants (KC_W, KC_S, KC_A, KC_D, KC_UP, KC_DOWN, KC_LEFT, KC_RIGHT, KC_SPACE, KC_ESC, KC_EXT=E0, KC_BRK=F0), and the opposite-direction function.
- One sub-module, `sync_edge`: 2-flop synchronizer plus rising-edge pulse, reused later for the PS2_CLK path.

Test Plan:
- Reset low 2 cycles -> p1_dir=01, p2_dir=11, read=0, start_req=0, last_code=00.
- Code 1D held high for 10 cycles -> exactly one read pulse, last_code=1D; p1_dir stays 01 until tick, then p1_dir=00.
- Sequence E0,75 then tick -> p2_dir=00. Sequence E0,F0,75 then tick -> p2_dir unchanged at 11.
- p1 committed RIGHT, code 1C (LEFT) then tick -> p1_dir stays 01. Same with NO_REVERSE=0 -> p1_dir=11.
- Code 29 -> start_req=1 until the next tick, then 0. Space capture coincident with tick -> start_req stays 1. Code 76 -> esc_pulse high for exactly 1 cycle.
- Code E0 then reset low, then code 75 -> treated as non-extended; p2 pending=UP; FSM back in IDLE. init_dirs and tick in the same cycle with pending p1=DOWN -> p1_dir=01.

Source files
------------

// File: rtl/lbike_pkg.sv
// Shared constants for the light-bike game: direction encoding, PS/2 set-2 scan codes,
// prefix-decoder states and the opposite-direction helper.
package lbike_pkg;

  localparam logic [1:0] UP    = 2'b00;
  localparam logic [1:0] RIGHT = 2'b01;
  localparam logic [1:0] DOWN  = 2'b10;
  localparam logic [1:0] LEFT  = 2'b11;

  localparam logic [7:0] KC_W     = 8'h1D;
  localparam logic [7:0] KC_S     = 8'h1B;
  localparam logic [7:0] KC_A     = 8'h1C;
  localparam logic [7:0] KC_D     = 8'h23;
  localparam logic [7:0] KC_UP    = 8'h75;
  localparam logic [7:0] KC_DOWN  = 8'h72;
  localparam logic [7:0] KC_LEFT  = 8'h6B;
  localparam logic [7:0] KC_RIGHT = 8'h74;
  localparam logic [7:0] KC_SPACE = 8'h29;
  localparam logic [7:0] KC_ESC   = 8'h76;
  localparam logic [7:0] KC_EXT   = 8'hE0;
  localparam logic [7:0] KC_BRK   = 8'hF0;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    EXT     = 2'b01,
    BRK     = 2'b10,
    EXT_BRK = 2'b11
  } pfx_state_t;

  function automatic logic [1:0] opposite(input logic [1:0] d);
    return d ^ 2'b10;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous level, plus a one-cycle rising-edge pulse.
// rise is high in the cycle after the second stage first sees the level high.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic s1;
  logic s2;
  logic prev;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign rise = s2 & ~prev;

endmodule

// File: rtl/ps2_cmd_decoder.sv
// PS/2 scan-code to game-command decoder: capture 3 edges after scan_ready rises, decode 1 later;
// read acknowledges each capture, direction changes commit only on tick.
module ps2_cmd_decoder
  import lbike_pkg::*;
#(
  parameter bit         NO_REVERSE  = 1'b1,
  parameter logic [1:0] P1_INIT_DIR = 2'b01,
  parameter logic [1:0] P2_INIT_DIR = 2'b11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_ready,
  input  logic [7:0] scan_code,
  output logic       read,
  input  logic       tick,
  input  logic       init_dirs,
  output logic [1:0] p1_dir,
  output logic [1:0] p2_dir,
  output logic       start_req,
  output logic       esc_pulse,
  output logic [7:0] last_code
);

  logic       code_rise;
  pfx_state_t state_q;
  pfx_state_t state_d;

  logic       p1_hit;
  logic [1:0] p1_code_dir;
  logic       p2_hit;
  logic [1:0] p2_code_dir;

  logic       p1_act;
  logic       p2_act;
  logic       start_set;
  logic       esc_set;

  logic [1:0] p1_pend;
  logic [1:0] p2_pend;
  logic [1:0] p1_ref;
  logic [1:0] p2_ref;
  logic       p1_ok;
  logic       p2_ok;

  sync_edge u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (scan_ready),
    .rise  (code_rise)
  );

  // read doubles as the "last_code holds a fresh code" strobe for the decoder
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_code <= 8'h00;
      read      <= 1'b0;
    end else begin
      read <= code_rise;
      if (code_rise) begin
        last_code <= scan_code;
      end
    end
  end

  always_comb begin
    p1_hit      = 1'b1;
    p1_code_dir = UP;
    case (last_code)
      KC_W:    p1_code_dir = UP;
      KC_S:    p1_code_dir = DOWN;
      KC_A:    p1_code_dir = LEFT;
      KC_D:    p1_code_dir = RIGHT;
      default: p1_hit      = 1'b0;
    endcase
  end

  always_comb begin
    p2_hit      = 1'b1;
    p2_code_dir = UP;
    case (last_code)
      KC_UP:    p2_code_dir = UP;
      KC_DOWN:  p2_code_dir = DOWN;
      KC_LEFT:  p2_code_dir = LEFT;
      KC_RIGHT: p2_code_dir = RIGHT;
      default:  p2_hit      = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    p1_act    = 1'b0;
    p2_act    = 1'b0;
    start_set = 1'b0;
    esc_set   = 1'b0;
    case (state_q)
      IDLE: begin
        if (read) begin
          if (last_code == KC_EXT) begin
            state_d = EXT;
          end else if (last_code == KC_BRK) begin
            state_d = BRK;
          end else begin
            p1_act    = p1_hit;
            p2_act    = p2_hit;
            start_set = (last_code == KC_SPACE);
            esc_set   = (last_code == KC_ESC);
          end
        end
      end
      EXT: begin
        if (read) begin
          if (last_code == KC_BRK) begin
            state_d = EXT_BRK;
          end else if (last_code == KC_EXT) begin
            state_d = EXT;
          end else begin
            state_d = IDLE;
            p2_act  = p2_hit;
          end
        end
      end
      BRK, EXT_BRK: begin
        if (read) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // on a tick the pending value is what becomes committed, so it is the value a reversal is judged against
  assign p1_ref = tick ? p1_pend : p1_dir;
  assign p2_ref = tick ? p2_pend : p2_dir;
  assign p1_ok  = !(NO_REVERSE && (p1_code_dir == opposite(p1_ref)));
  assign p2_ok  = !(NO_REVERSE && (p2_code_dir == opposite(p2_ref)));

  always_ff @(posedge clk) begin
    if (!reset) begin
      p1_pend   <= P1_INIT_DIR;
      p2_pend   <= P2_INIT_DIR;
      p1_dir    <= P1_INIT_DIR;
      p2_dir    <= P2_INIT_DIR;
      start_req <= 1'b0;
      esc_pulse <= 1'b0;
    end else begin
      esc_pulse <= esc_set;
      if (start_set) begin
        start_req <= 1'b1;
      end else if (tick) begin
        start_req <= 1'b0;
      end
      if (init_dirs) begin
        p1_pend <= P1_INIT_DIR;
        p2_pend <= P2_INIT_DIR;
        p1_dir  <= P1_INIT_DIR;
        p2_dir  <= P2_INIT_DIR;
      end else begin
        if (tick) begin
          p1_dir <= p1_pend;
          p2_dir <= p2_pend;
        end
        if (p1_act && p1_ok) begin
          p1_pend <= p1_code_dir;
        end
        if (p2_act && p2_ok) begin
          p2_pend <= p2_code_dir;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_cmd_decoder.sv
// Directed bench for ps2_cmd_decoder; a second instance runs with reversal allowed.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_ps2_cmd_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scan_ready = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       tick = 1'b0;
  logic       init_dirs = 1'b0;

  logic       read;
  logic [1:0] p1_dir;
  logic [1:0] p2_dir;
  logic       start_req;
  logic       esc_pulse;
  logic [7:0] last_code;

  logic       nr_read;
  logic [1:0] nr_p1_dir;
  logic [1:0] nr_p2_dir;
  logic       nr_start_req;
  logic       nr_esc_pulse;
  logic [7:0] nr_last_code;

  int n_checks = 0;
  int n_fail   = 0;
  int rd_cnt;
  int esc_cnt;

  always #5 clk = ~clk;

  ps2_cmd_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .scan_ready (scan_ready),
    .scan_code  (scan_code),
    .read       (read),
    .tick       (tick),
    .init_dirs  (init_dirs),
    .p1_dir     (p1_dir),
    .p2_dir     (p2_dir),
    .start_req  (start_req),
    .esc_pulse  (esc_pulse),
    .last_code  (last_code)
  );

  ps2_cmd_decoder #(.NO_REVERSE(1'b0)) dut_nr (
    .clk        (clk),
    .reset      (reset),
    .scan_ready (scan_ready),
    .scan_code  (scan_code),
    .read       (nr_read),
    .tick       (tick),
    .init_dirs  (init_dirs),
    .p1_dir     (nr_p1_dir),
    .p2_dir     (nr_p2_dir),
    .start_req  (nr_start_req),
    .esc_pulse  (nr_esc_pulse),
    .last_code  (nr_last_code)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // hold the code for `hold` cycles, release, let the synchronizer drain; count acks and escapes
  task automatic send_code(input logic [7:0] code, input int hold);
    rd_cnt  = 0;
    esc_cnt = 0;
    @(negedge clk);
    scan_code  = code;
    scan_ready = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (read) rd_cnt++;
      if (esc_pulse) esc_cnt++;
    end
    scan_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (read) rd_cnt++;
      if (esc_pulse) esc_cnt++;
    end
  endtask

  task automatic do_tick();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic do_init();
    @(negedge clk);
    init_dirs = 1'b1;
    @(negedge clk);
    init_dirs = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    cycles(2);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    cycles(2);
    check("rst_p1", p1_dir, 2'b01);
    check("rst_p2", p2_dir, 2'b11);
    check("rst_read", read, 1'b0);
    check("rst_start", start_req, 1'b0);
    check("rst_last", last_code, 8'h00);
    check("rst_esc", esc_pulse, 1'b0);
    reset = 1'b1;
    cycles(1);

    send_code(8'h1D, 10);
    check("w_reads", rd_cnt, 1);
    check("w_last", last_code, 8'h1D);
    check("w_pre_tick", p1_dir, 2'b01);
    do_tick();
    check("w_post_tick", p1_dir, 2'b00);

    do_init();
    check("init_p1", p1_dir, 2'b01);
    check("init_p2", p2_dir, 2'b11);
    send_code(8'hE0, 5);
    send_code(8'hF0, 5);
    send_code(8'h75, 5);
    do_tick();
    check("ext_brk_p2", p2_dir, 2'b11);
    send_code(8'hE0, 5);
    send_code(8'h75, 5);
    check("ext_last", last_code, 8'h75);
    do_tick();
    check("ext_up_p2", p2_dir, 2'b00);

    do_init();
    send_code(8'h1C, 5);
    do_tick();
    check("norev_p1", p1_dir, 2'b01);
    check("rev_ok_p1", nr_p1_dir, 2'b11);

    send_code(8'h29, 5);
    check("space_set", start_req, 1'b1);
    cycles(3);
    check("space_hold", start_req, 1'b1);
    do_tick();
    check("space_clr", start_req, 1'b0);

    // space decode lands on the 4th edge after scan_ready rises; raise tick to meet it
    @(negedge clk);
    scan_code  = 8'h29;
    scan_ready = 1'b1;
    cycles(3);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check("space_tick_win", start_req, 1'b1);
    scan_ready = 1'b0;
    cycles(4);
    do_tick();
    check("space_tick_clr", start_req, 1'b0);

    send_code(8'h76, 6);
    check("esc_once", esc_cnt, 1);
    check("esc_read", rd_cnt, 1);

    send_code(8'hE0, 5);
    do_reset();
    check("rst2_p2", p2_dir, 2'b11);
    check("rst2_last", last_code, 8'h00);
    send_code(8'h75, 5);
    check("rst2_last75", last_code, 8'h75);
    check("rst2_pre_tick", p2_dir, 2'b11);
    do_tick();
    check("rst2_p2_up", p2_dir, 2'b00);
    send_code(8'hE0, 5);
    do_reset();
    send_code(8'h1D, 5);
    do_tick();
    check("rst2_idle_p1", p1_dir, 2'b00);

    do_init();
    send_code(8'h1B, 5);
    @(negedge clk);
    init_dirs = 1'b1;
    tick      = 1'b1;
    @(negedge clk);
    init_dirs = 1'b0;
    tick      = 1'b0;
    check("init_tick_p1", p1_dir, 2'b01);
    do_tick();
    check("init_pend_p1", p1_dir, 2'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
